// File: rtl/box_scan_sequencer_pkg.sv
// Shared definitions for the box scan sequencer: FSM states, the box-printer geometry and the empty-box code.
// Holds types and constants only, so it has no latency and no flow control.
package box_scan_sequencer_pkg;

    localparam int GEO_BUFFERS = 4;
    localparam int GEO_BOXES   = 6;
    localparam int BUF_W       = 2;
    localparam int BOX_W       = 3;

    localparam logic [2:0] EMPTY_CODE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_FINISH
    } scan_state_t;

endpackage

// File: rtl/box_scan_sequencer_scan_index_counter.sv
// Nested buffer/box index: box runs 1..NUM_BOXES inside buffer 0..NUM_BUFFERS-1; load returns to (0,1).
// Registered, advances one step per inc; wraps to the origin after the final pair; load beats inc.
module scan_index_counter
    import box_scan_sequencer_pkg::*;
#(
    parameter int NUM_BUFFERS = GEO_BUFFERS,
    parameter int NUM_BOXES   = GEO_BOXES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [BUF_W-1:0] buffer,
    output logic [BOX_W-1:0] box,
    output logic             box_wrap,
    output logic             buf_last
);

    assign box_wrap = (box == BOX_W'(NUM_BOXES));
    assign buf_last = (buffer == BUF_W'(NUM_BUFFERS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer <= '0;
            box    <= BOX_W'(1);
        end else if (load) begin
            buffer <= '0;
            box    <= BOX_W'(1);
        end else if (inc) begin
            if (box_wrap) begin
                box    <= BOX_W'(1);
                buffer <= buf_last ? '0 : buffer + BUF_W'(1);
            end else begin
                box <= box + BOX_W'(1);
            end
        end
    end

endmodule

// File: rtl/box_scan_sequencer.sv
// Per-frame scan of every (buffer, box) pair, handing each occupied box to the renderer via req/done.
// All outputs registered; 3 cycles per skipped box; draw_req held until draw_done or DONE_TIMEOUT expiry.
module box_scan_sequencer
    import box_scan_sequencer_pkg::*;
#(
    parameter int NUM_BUFFERS   = GEO_BUFFERS,
    parameter int NUM_BOXES     = GEO_BOXES,
    parameter int SETTLE_CYCLES = 1,
    parameter int DONE_TIMEOUT  = 255,
    parameter bit SKIP_EMPTY    = 1'b1
) (
    input  logic             F25MHZ,
    input  logic             RST,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             clear_err,
    input  logic [2:0]       number_in,
    input  logic             draw_done,
    output logic [BUF_W-1:0] buffer,
    output logic [BOX_W-1:0] box,
    output logic             draw_req,
    output logic             scan_busy,
    output logic             scan_done,
    output logic             timeout_err,
    output logic             overrun_err
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int TMO_W    = $clog2(DONE_TIMEOUT + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(DONE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(DONE_TIMEOUT);

    scan_state_t         state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                draw_req_d;
    logic                scan_done_d;
    logic                idx_load, idx_inc;
    logic                box_wrap, buf_last;
    logic                timeout_evt, overrun_evt;

    scan_index_counter #(
        .NUM_BUFFERS (NUM_BUFFERS),
        .NUM_BOXES   (NUM_BOXES)
    ) u_index (
        .clk      (F25MHZ),
        .rst      (RST),
        .load     (idx_load),
        .inc      (idx_inc),
        .buffer   (buffer),
        .box      (box),
        .box_wrap (box_wrap),
        .buf_last (buf_last)
    );

    assign overrun_evt = frame_start && (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        tmo_d       = tmo_q;
        draw_req_d  = draw_req;
        scan_done_d = 1'b0;
        idx_load    = 1'b0;
        idx_inc     = 1'b0;
        timeout_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start && enable) begin
                    idx_load = 1'b1;
                    settle_d = '0;
                    state_d  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // number_in reflects the current selects only on the last settle cycle
                if (settle_q == SETTLE_LAST) begin
                    if (SKIP_EMPTY && (number_in == EMPTY_CODE)) begin
                        state_d = ST_NEXT;
                    end else begin
                        draw_req_d = 1'b1;
                        tmo_d      = '0;
                        state_d    = ST_WAIT_DONE;
                    end
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (draw_done) begin
                    draw_req_d = 1'b0;
                    state_d    = ST_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_evt = 1'b1;
                    draw_req_d  = 1'b0;
                    state_d     = ST_NEXT;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_NEXT: begin
                if (!enable) begin
                    idx_load = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!box_wrap || !buf_last) begin
                    idx_inc  = 1'b1;
                    settle_d = '0;
                    state_d  = ST_SELECT;
                end else begin
                    scan_done_d = 1'b1;
                    state_d     = ST_FINISH;
                end
            end
            ST_FINISH: begin
                idx_load = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                idx_load   = 1'b1;
                draw_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Error flags are sticky; a new event in the clear cycle keeps the flag set
    always_ff @(posedge F25MHZ or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            tmo_q       <= '0;
            draw_req    <= 1'b0;
            scan_busy   <= 1'b0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            draw_req    <= draw_req_d;
            scan_busy   <= (state_d != ST_IDLE);
            scan_done   <= scan_done_d;
            timeout_err <= timeout_evt || (timeout_err && !clear_err);
            overrun_err <= overrun_evt || (overrun_err && !clear_err);
        end
    end

endmodule

// File: tb/tb_box_scan_sequencer.sv
// Directed bench: table of whole-frame scans plus hand sequences for overrun, enable abort and mid-scan reset.
module tb_box_scan_sequencer;

    logic       F25MHZ = 1'b0;
    logic       RST;
    logic       enable;
    logic       frame_start;
    logic       clear_err;
    logic [2:0] number_in;
    logic       draw_done;
    logic [1:0] buffer;
    logic [2:0] box;
    logic       draw_req;
    logic       scan_busy;
    logic       scan_done;
    logic       timeout_err;
    logic       overrun_err;

    int tests = 0;
    int fails = 0;

    logic [2:0] occ [0:3][0:7];
    int render_delay;
    int req_age;

    int sel_b[$];
    int sel_x[$];
    int req_count, req_cycles, done_count, first_req_buf, first_req_box, tmo_req;
    logic prev_busy, prev_req, prev_tmo;
    logic [1:0] prev_buf;
    logic [2:0] prev_box;

    typedef struct {
        string name;
        int    mode;
        int    delay;
        int    exp_sel;
        int    exp_reqs;
        int    exp_req_cyc;
        int    exp_lat;
        int    exp_tmo;
        int    exp_rb;
        int    exp_rx;
        int    exp_tmo_req;
    } vec_t;

    always #20 F25MHZ = ~F25MHZ;

    // Box printer stand-in: content of the selected box
    assign number_in = occ[buffer][box];

    box_scan_sequencer dut (
        .F25MHZ      (F25MHZ),
        .RST         (RST),
        .enable      (enable),
        .frame_start (frame_start),
        .clear_err   (clear_err),
        .number_in   (number_in),
        .draw_done   (draw_done),
        .buffer      (buffer),
        .box         (box),
        .draw_req    (draw_req),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    // Renderer: answers in the render_delay-th cycle of draw_req; 0 means never
    initial begin
        draw_done = 1'b0;
        req_age   = 0;
        forever begin
            @(negedge F25MHZ);
            if (draw_req && render_delay != 0) begin
                req_age   = req_age + 1;
                draw_done = (req_age == render_delay);
            end else begin
                req_age   = 0;
                draw_done = 1'b0;
            end
        end
    end

    initial begin
        prev_busy = 1'b0;
        prev_req  = 1'b0;
        prev_tmo  = 1'b0;
        prev_buf  = 2'd0;
        prev_box  = 3'd1;
        forever begin
            @(negedge F25MHZ);
            if (scan_busy && (!prev_busy || buffer != prev_buf || box != prev_box)) begin
                sel_b.push_back(int'(buffer));
                sel_x.push_back(int'(box));
            end
            if (draw_req) begin
                req_cycles = req_cycles + 1;
                if (!prev_req) begin
                    req_count = req_count + 1;
                    if (first_req_buf < 0) begin
                        first_req_buf = int'(buffer);
                        first_req_box = int'(box);
                    end
                end
            end
            if (scan_done) done_count = done_count + 1;
            if (timeout_err && !prev_tmo && tmo_req < 0) tmo_req = req_count;
            prev_busy = scan_busy;
            prev_req  = draw_req;
            prev_tmo  = timeout_err;
            prev_buf  = buffer;
            prev_box  = box;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        tests = tests + 1;
        if (actual != expected) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_mon();
        sel_b.delete();
        sel_x.delete();
        req_count     = 0;
        req_cycles    = 0;
        done_count    = 0;
        first_req_buf = -1;
        first_req_box = -1;
        tmo_req       = -1;
    endtask

    task automatic fill(input int mode);
        int v;
        for (int b = 0; b < 4; b++) begin
            for (int x = 0; x < 8; x++) begin
                case (mode)
                    1:       v = (b == 1 && x == 3) ? 2 : 4;
                    2:       v = x % 4;
                    3:       v = ((b + x) % 2 == 0) ? (b + x) % 4 : 4;
                    4:       v = (b == 2 && x == 2) ? 1 : 4;
                    5:       v = (b == 1 && x == 2) ? 3 : 4;
                    default: v = 4;
                endcase
                occ[b][x] = 3'(v);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge F25MHZ);
    endtask

    // lat = edges after the frame_start sampling edge until scan_done is seen high
    task automatic run_scan(input int overrun_at, input int budget, output int lat);
        int n;
        lat = -1;
        @(negedge F25MHZ);
        frame_start = 1'b1;
        n = 0;
        while (n < budget && lat < 0) begin
            @(negedge F25MHZ);
            n = n + 1;
            frame_start = (n == overrun_at);
            if (scan_done) lat = n - 1;
        end
        frame_start = 1'b0;
    endtask

    function automatic int order_errors();
        int e = 0;
        foreach (sel_b[i]) begin
            if (sel_b[i] != i / 6 || sel_x[i] != i % 6 + 1) e = e + 1;
        end
        return e;
    endfunction

    function automatic vec_t mk(input string name, input int mode, input int delay, input int sel,
                                input int reqs, input int cyc, input int lat, input int tmo,
                                input int rb, input int rx, input int treq);
        vec_t r;
        r.name = name; r.mode = mode; r.delay = delay; r.exp_sel = sel;
        r.exp_reqs = reqs; r.exp_req_cyc = cyc; r.exp_lat = lat; r.exp_tmo = tmo;
        r.exp_rb = rb; r.exp_rx = rx; r.exp_tmo_req = treq;
        return r;
    endfunction

    initial begin
        vec_t vecs[4];
        int lat;
        int n;

        vecs[0] = mk("all_empty", 0, 5, 24,  0,    0,   72, 0, -1, -1, -1);
        vecs[1] = mk("one_box",   1, 5, 24,  1,    5,   77, 0,  1,  3, -1);
        vecs[2] = mk("no_answer", 2, 0, 24, 24, 6120, 6192, 1,  0,  1,  1);
        vecs[3] = mk("checker",   3, 2, 24, 12,   24,   96, 0,  0,  2, -1);

        RST = 1'b1; enable = 1'b1; frame_start = 1'b0; clear_err = 1'b0;
        render_delay = 5;
        fill(0);
        clear_mon();
        wait_cycles(3);
        check("rst.buffer", int'(buffer), 0);
        check("rst.box", int'(box), 1);
        check("rst.draw_req", int'(draw_req), 0);
        check("rst.scan_busy", int'(scan_busy), 0);
        check("rst.scan_done", int'(scan_done), 0);
        check("rst.timeout_err", int'(timeout_err), 0);
        check("rst.overrun_err", int'(overrun_err), 0);
        RST = 1'b0;
        wait_cycles(2);

        for (int v = 0; v < 4; v++) begin
            fill(vecs[v].mode);
            render_delay = vecs[v].delay;
            clear_err = 1'b1;
            @(negedge F25MHZ);
            clear_err = 1'b0;
            @(negedge F25MHZ);
            clear_mon();
            run_scan(0, 7000, lat);
            wait_cycles(3);
            check({vecs[v].name, ".latency"}, lat, vecs[v].exp_lat);
            check({vecs[v].name, ".selections"}, sel_b.size(), vecs[v].exp_sel);
            check({vecs[v].name, ".order_errs"}, order_errors(), 0);
            check({vecs[v].name, ".reqs"}, req_count, vecs[v].exp_reqs);
            check({vecs[v].name, ".req_cycles"}, req_cycles, vecs[v].exp_req_cyc);
            check({vecs[v].name, ".done_pulses"}, done_count, 1);
            check({vecs[v].name, ".timeout_err"}, int'(timeout_err), vecs[v].exp_tmo);
            check({vecs[v].name, ".first_req_buf"}, first_req_buf, vecs[v].exp_rb);
            check({vecs[v].name, ".first_req_box"}, first_req_box, vecs[v].exp_rx);
            check({vecs[v].name, ".tmo_after_req"}, tmo_req, vecs[v].exp_tmo_req);
            check({vecs[v].name, ".busy_after"}, int'(scan_busy), 0);
            check({vecs[v].name, ".buffer_after"}, int'(buffer), 0);
            check({vecs[v].name, ".box_after"}, int'(box), 1);
        end

        // Second frame_start mid-scan
        fill(0);
        clear_err = 1'b1;
        @(negedge F25MHZ);
        clear_err = 1'b0;
        @(negedge F25MHZ);
        clear_mon();
        run_scan(10, 200, lat);
        wait_cycles(3);
        check("overrun.latency", lat, 72);
        check("overrun.flag", int'(overrun_err), 1);
        check("overrun.order_errs", order_errors(), 0);
        check("overrun.selections", sel_b.size(), 24);
        wait_cycles(80);
        check("overrun.done_pulses", done_count, 1);
        check("overrun.busy_after", int'(scan_busy), 0);
        clear_err = 1'b1;
        @(negedge F25MHZ);
        clear_err = 1'b0;
        check("overrun.cleared", int'(overrun_err), 0);

        // Drop enable while (2,2) is being rendered
        fill(4);
        render_delay = 5;
        clear_mon();
        @(negedge F25MHZ);
        frame_start = 1'b1;
        @(negedge F25MHZ);
        frame_start = 1'b0;
        n = 0;
        while (!draw_req && n < 200) begin
            @(negedge F25MHZ);
            n = n + 1;
        end
        check("abort.req_buffer", int'(buffer), 2);
        check("abort.req_box", int'(box), 2);
        enable = 1'b0;
        n = 0;
        while (draw_req && n < 20) begin
            @(negedge F25MHZ);
            n = n + 1;
        end
        wait_cycles(5);
        check("abort.req_cycles", req_cycles, 5);
        check("abort.busy", int'(scan_busy), 0);
        check("abort.buffer", int'(buffer), 0);
        check("abort.box", int'(box), 1);
        check("abort.done_pulses", done_count, 0);
        check("abort.selections", sel_b.size(), 14);
        enable = 1'b1;

        // Asynchronous reset while draw_req is held at (1,2)
        fill(5);
        render_delay = 0;
        clear_mon();
        @(negedge F25MHZ);
        frame_start = 1'b1;
        @(negedge F25MHZ);
        frame_start = 1'b0;
        n = 0;
        while (!draw_req && n < 200) begin
            @(negedge F25MHZ);
            n = n + 1;
        end
        check("arst.pre_req", int'(draw_req), 1);
        wait_cycles(3);
        #3 RST = 1'b1;
        #1;
        check("arst.draw_req", int'(draw_req), 0);
        check("arst.scan_busy", int'(scan_busy), 0);
        check("arst.buffer", int'(buffer), 0);
        check("arst.box", int'(box), 1);
        @(negedge F25MHZ);
        RST = 1'b0;
        wait_cycles(2);
        check("arst.done_pulses", done_count, 0);
        fill(0);
        clear_mon();
        run_scan(0, 200, lat);
        wait_cycles(3);
        check("arst.restart_latency", lat, 72);
        check("arst.restart_order", order_errors(), 0);
        check("arst.restart_selections", sel_b.size(), 24);
        check("arst.restart_done", done_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
